// File: rtl/gate_op_pkg.sv
// Shared opcode, width and state definitions for the gate-op arbiter and its bitwise datapath.
package gate_op_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND  = 3'd0;
  localparam logic [OP_W-1:0] OP_OR   = 3'd1;
  localparam logic [OP_W-1:0] OP_NOT  = 3'd2;
  localparam logic [OP_W-1:0] OP_NAND = 3'd3;
  localparam logic [OP_W-1:0] OP_NOR  = 3'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 3'd5;
  localparam logic [OP_W-1:0] OP_XNOR = 3'd6;
  localparam logic [OP_W-1:0] OP_RSVD = 3'd7;

  // Result-stage occupancy: EMPTY has no result, FULL holds one awaiting consumption.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage : gate_op_pkg

// File: rtl/gate_vector_alu.sv
// Combinational WIDTH-bit bitwise gate unit; reserved opcode yields zero data and err=1.
module gate_vector_alu
  import gate_op_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] data,
  output logic             err
);

  always_comb begin
    data = '0;
    err  = 1'b0;
    case (op)
      OP_AND:  data = a & b;
      OP_OR:   data = a | b;
      OP_NOT:  data = ~a;
      OP_NAND: data = ~(a & b);
      OP_NOR:  data = ~(a | b);
      OP_XOR:  data = a ^ b;
      OP_XNOR: data = ~(a ^ b);
      default: err  = 1'b1;
    endcase
  end

endmodule : gate_vector_alu

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one bitwise gate datapath among NUM_REQ requesters,
// with a single registered result stage and valid/ready handshakes on both sides.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [OP_W*NUM_REQ-1:0]      req_op,
  input  logic [WIDTH*NUM_REQ-1:0]     req_a,
  input  logic [WIDTH*NUM_REQ-1:0]     req_b,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [WIDTH-1:0]             res_data,
  output logic [$clog2(NUM_REQ)-1:0]   res_id,
  output logic                         res_err,
  output logic [CNT_W-1:0]             done_cnt
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;

  logic              can_accept;
  logic              found;
  logic [ID_W-1:0]   winner;
  logic [ID_W-1:0]   cand;
  int unsigned       pos;
  logic              accept;

  logic [OP_W-1:0]   op_arr [NUM_REQ];
  logic [WIDTH-1:0]  a_arr  [NUM_REQ];
  logic [WIDTH-1:0]  b_arr  [NUM_REQ];

  logic [OP_W-1:0]   win_op;
  logic [WIDTH-1:0]  win_a;
  logic [WIDTH-1:0]  win_b;
  logic [WIDTH-1:0]  alu_data;
  logic              alu_err;

  // Unpack the flat request buses into per-requester views.
  always_comb begin
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = req_op[OP_W*i +: OP_W];
      a_arr[i]  = req_a[WIDTH*i +: WIDTH];
      b_arr[i]  = req_b[WIDTH*i +: WIDTH];
    end
  end

  // A new operation fits if the stage is empty or its result leaves this cycle.
  assign can_accept = (state == ST_EMPTY) | res_ready;

  // Rotated priority search starting at rr_ptr.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    pos    = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos = 32'(rr_ptr) + k;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      cand = ID_W'(pos);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  assign accept = found & can_accept & ~rst;

  always_comb begin
    req_ready = '0;
    if (accept) begin
      req_ready[winner] = 1'b1;
    end
  end

  assign win_op = op_arr[winner];
  assign win_a  = a_arr[winner];
  assign win_b  = b_arr[winner];

  gate_vector_alu #(
    .WIDTH (WIDTH)
  ) u_alu (
    .op   (win_op),
    .a    (win_a),
    .b    (win_b),
    .data (alu_data),
    .err  (alu_err)
  );

  // Result stage FSM with pointer and counter bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= '0;
      res_err   <= 1'b0;
      rr_ptr    <= '0;
      done_cnt  <= '0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state     <= ST_FULL;
            res_valid <= 1'b1;
          end
        end
        ST_FULL: begin
          if (res_ready && !accept) begin
            state     <= ST_EMPTY;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_EMPTY;
          res_valid <= 1'b0;
        end
      endcase

      if (accept) begin
        res_data <= alu_data;
        res_id   <= winner;
        res_err  <= alu_err;
        rr_ptr   <= (winner == LAST_ID) ? '0 : ID_W'(winner + 1'b1);
        if (done_cnt != {CNT_W{1'b1}}) begin
          done_cnt <= done_cnt + 1'b1;
        end
      end
    end
  end

endmodule : gate_op_arbiter

// File: tb/tb_gate_op_arbiter.sv
// Self-checking bench for gate_op_arbiter: directed tables, corner sequences and
// randomized traffic compared against a transaction-level reference model.
module tb_gate_op_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 8;
  localparam int unsigned CW = 16;

  logic              clk;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [3*N-1:0]    req_op;
  logic [W*N-1:0]    req_a;
  logic [W*N-1:0]    req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_data;
  logic [1:0]        res_id;
  logic              res_err;
  logic [CW-1:0]     done_cnt;

  gate_op_arbiter #(.NUM_REQ(N), .WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .done_cnt  (done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one result slot, a rotating start index and an op counter.
  bit          m_known = 0;
  bit          m_valid;
  logic [W-1:0] m_data;
  int          m_id;
  bit          m_err;
  int          m_ptr;
  int          m_cnt;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } sweep_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return ~a;
      3'd3: return ~(a & b);
      3'd4: return ~(a | b);
      3'd5: return a ^ b;
      3'd6: return ~(a ^ b);
      default: return '0;
    endcase
  endfunction

  task automatic set_req(input int i, input logic v, input logic [2:0] op,
                         input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]     = v;
    req_op[3*i +: 3] = op;
    req_a[W*i +: W]  = a;
    req_b[W*i +: W]  = b;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 3'd0, '0, '0);
  endtask

  // Check one cycle against the model, advance the model, then cross the clock edge.
  task automatic tick();
    int          w;
    int          idx;
    logic [N-1:0] exp_rdy;
    bit          can;
    logic [2:0]  wop;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_ptr + k) % N;
      if (w < 0 && req_valid[idx]) w = idx;
    end
    can = !m_valid || res_ready;
    exp_rdy = '0;
    if (!rst && can && w >= 0) exp_rdy[w] = 1'b1;
    if (rst || m_known) check("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (m_known) begin
      check("res_valid", 32'(res_valid), 32'(m_valid));
      check("done_cnt", 32'(done_cnt), 32'(m_cnt));
      if (m_valid) begin
        check("res_data", 32'(res_data), 32'(m_data));
        check("res_id", 32'(res_id), 32'(m_id));
        check("res_err", 32'(res_err), 32'(m_err));
      end
    end
    if (rst) begin
      m_known = 1; m_valid = 0; m_data = '0; m_id = 0; m_err = 0; m_ptr = 0; m_cnt = 0;
    end else if (m_known) begin
      if (exp_rdy != '0) begin
        wop     = req_op[3*w +: 3];
        m_valid = 1;
        m_data  = ref_op(wop, req_a[W*w +: W], req_b[W*w +: W]);
        m_id    = w;
        m_err   = (wop == 3'd7);
        m_ptr   = (w + 1) % N;
        if (m_cnt < (1 << CW) - 1) m_cnt++;
      end else if (res_ready) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  sweep_vec_t   sweep [8];
  logic [W-1:0] held;

  initial begin
    sweep[0] = '{3'd0, 8'h0A, 1'b0};
    sweep[1] = '{3'd1, 8'hAF, 1'b0};
    sweep[2] = '{3'd2, 8'h55, 1'b0};
    sweep[3] = '{3'd3, 8'hF5, 1'b0};
    sweep[4] = '{3'd4, 8'h50, 1'b0};
    sweep[5] = '{3'd5, 8'hA5, 1'b0};
    sweep[6] = '{3'd6, 8'h5A, 1'b0};
    sweep[7] = '{3'd7, 8'h00, 1'b1};

    rst = 1'b1; res_ready = 1'b1;
    req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
    @(posedge clk); #1;

    // Reset held with every requester asking.
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, 8'hFF, 8'hFF);
    do_reset();
    clear_reqs();
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_res_data", 32'(res_data), 32'h00);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);

    // Single XOR on requester 0.
    set_req(0, 1'b1, 3'd5, 8'hF0, 8'h3C);
    #1 check("single_ready", 32'(req_ready), 32'h1);
    tick();
    clear_reqs();
    check("single_valid", 32'(res_valid), 32'd1);
    check("single_data", 32'(res_data), 32'hCC);
    check("single_id", 32'(res_id), 32'd0);
    check("single_err", 32'(res_err), 32'd0);

    // Opcode sweep on requester 1.
    do_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      set_req(1, 1'b1, sweep[k].op, 8'hAA, 8'h0F);
      tick();
      check("sweep_data", 32'(res_data), 32'(sweep[k].exp_data));
      check("sweep_err", 32'(res_err), 32'(sweep[k].exp_err));
      check("sweep_id", 32'(res_id), 32'd1);
    end
    clear_reqs();
    check("sweep_cnt", 32'(done_cnt), 32'd8);

    // Round-robin with everyone valid.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'($urandom_range(0, 6)), 8'($urandom), 8'($urandom));
      tick();
      check("rr_id", 32'(res_id), 32'(k % N));
      check("rr_valid", 32'(res_valid), 32'd1);
    end

    // Backpressure: hold a result while requester 2 waits.
    clear_reqs();
    res_ready = 1'b1;
    tick();
    set_req(0, 1'b1, 3'd1, 8'h12, 8'h40);
    res_ready = 1'b0;
    tick();
    held = res_data;
    check("bp_held_data", 32'(held), 32'h52);
    set_req(0, 1'b0, 3'd0, '0, '0);
    set_req(2, 1'b1, 3'd0, 8'h3C, 8'h0F);
    for (int k = 0; k < 5; k++) begin
      #1 check("bp_ready", 32'(req_ready), 32'h0);
      tick();
      check("bp_data", 32'(res_data), 32'(held));
      check("bp_valid", 32'(res_valid), 32'd1);
    end
    res_ready = 1'b1;
    #1 check("bp_release_ready", 32'(req_ready), 32'h4);
    tick();
    clear_reqs();
    check("bp_next_valid", 32'(res_valid), 32'd1);
    check("bp_next_id", 32'(res_id), 32'd2);
    check("bp_next_data", 32'(res_data), 32'h0C);

    // Reset in the middle of activity.
    do_reset();
    res_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd5, 8'($urandom), 8'($urandom));
      tick();
    end
    clear_reqs();
    set_req(2, 1'b1, 3'd6, 8'h11, 8'h22);
    tick();
    check("mid_cnt", 32'(done_cnt), 32'd10);
    check("mid_valid", 32'(res_valid), 32'd1);
    check("mid_id", 32'(res_id), 32'd2);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3'd0, 8'hFF, 8'h0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", 32'(res_valid), 32'd0);
    check("mid_rst_cnt", 32'(done_cnt), 32'd0);
    #1 check("mid_rst_grant", 32'(req_ready), 32'h1);
    tick();
    check("mid_rst_id", 32'(res_id), 32'd0);

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) == 0);
      for (int i = 0; i < N; i++)
        set_req(i, 1'($urandom_range(0, 1)), 3'($urandom), 8'($urandom), 8'($urandom));
      res_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_gate_op_arbiter
